// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants for the 16-bit carry-lookahead adder
//
// Purpose: holds the datapath width and the lookahead group size so that
// cla16 and cla4 agree on how the word is split into groups.
// Ports: none (package).
package cla_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

endpackage

// File: rtl/cla4.sv
// rtl/cla4.sv - 4-bit carry-lookahead group with group generate/propagate
//
// Purpose: computes a 4-bit sum with all internal carries derived directly
// from ci and the per-bit generate/propagate terms (no ripple), and exports
// the group generate/propagate for the second-level lookahead.
// Ports:
//   a, b  in  [3:0]  group slices of the addends
//   ci    in  1      carry into bit 0 of the group
//   s     out [3:0]  group sum
//   gg    out 1      group generate (group produces a carry by itself)
//   gp    out 1      group propagate (group passes ci through unchanged)
module cla4
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products of ci and lower g/p terms.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c;

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla16.sv
// rtl/cla16.sv - 16-bit two-level carry-lookahead adder with registered result
//
// Purpose: {Cout,S} = A + B + Cin, sampled when in_valid is high and
// presented one cycle later with a single-cycle out_valid pulse.
// Four cla4 groups are tied together by an inline second-level lookahead
// so no carry ripples between groups.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   A, B       in   16  unsigned addends
//   Cin        in   1   carry into bit 0
//   in_valid   in   1   sample A/B/Cin on this edge
//   S          out  16  registered sum
//   Cout       out  1   registered carry out of bit 15
//   out_valid  out  1   S/Cout hold a fresh result this cycle
module cla16
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  logic [NGROUPS-1:0] gg;
  logic [NGROUPS-1:0] gp;
  logic [NGROUPS:0]   gc;   // gc[k] = carry into group k; gc[4] = c16
  logic [WIDTH-1:0]   sum;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla4 u_cla4 (
      .a  (A[k*GROUP +: GROUP]),
      .b  (B[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .s  (sum[k*GROUP +: GROUP]),
      .gg (gg[k]),
      .gp (gp[k])
    );
  end

  // Second-level lookahead: every group carry comes straight from Cin and
  // the group G/P terms, so c16 does not wait on c4/c8/c12.
  assign gc[0] = Cin;
  assign gc[1] = gg[0] | (gp[0] & Cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & Cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

  // S/Cout only load on a valid sample and otherwise hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= gc[NGROUPS];
      end
    end
  end

endmodule

// File: tb/tb_cla16.sv
// tb/tb_cla16.sv - directed and random self-checking bench for cla16
module tb_cla16;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        in_valid;
  logic [15:0] S;
  logic        Cout;
  logic        out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  cla16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one vector at the falling edge, then sample 1 time unit after the
  // next rising edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = ci; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic add_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [16:0] exp);
    drive(a, b, ci, 1'b1);
    check({tag, " sum"}, {15'd0, Cout, S}, {15'd0, exp});
    check({tag, " vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  logic [15:0] ra, rb;
  logic        rc;
  logic [16:0] rexp;

  initial begin
    rst_n = 1'b1; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {15'd0, Cout, S}, 32'd0);
    check("rst_async_vld", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {14'd0, out_valid, Cout, S}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single vectors, including the idle cycle between them.
    add_check("basic",    16'h1234, 16'h1001, 1'b0, 17'h02235);
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    check("idle_vld", {31'd0, out_valid}, 32'd0);
    check("idle_hold", {15'd0, Cout, S}, 32'h02235);
    add_check("ovf",      16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    add_check("cin_only", 16'h0000, 16'h0000, 1'b1, 17'h00001);
    add_check("msb_ovf",  16'h8000, 16'h8000, 1'b0, 17'h10000);
    add_check("max_all",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);

    // Back-to-back stream, then idle with changed inputs -> hold.
    add_check("s0", 16'h1234, 16'h1001, 1'b0, 17'h02235);
    add_check("s1", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    add_check("s2", 16'h0F0F, 16'h00FF, 1'b0, 17'h0100E);
    add_check("s3", 16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);
    add_check("chain", 16'hAAAA, 16'h5555, 1'b1, 17'h10000);
    drive(16'h1111, 16'h2222, 1'b1, 1'b0);
    check("hold_vld", {31'd0, out_valid}, 32'd0);
    check("hold_val", {15'd0, Cout, S}, 32'h10000);
    drive(16'h1111, 16'h2222, 1'b1, 1'b0);
    check("hold_val2", {15'd0, Cout, S}, 32'h10000);

    // Mid-stream async reset: outputs clear without a clock edge.
    add_check("pre_rst", 16'h7FFF, 16'h7FFF, 1'b1, 17'h0FFFF);
    @(negedge clk);
    in_valid = 1'b1; A = 16'h1234; B = 16'h4321;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst", {14'd0, out_valid, Cout, S}, 32'd0);
    // Reset held across an edge with in_valid=1: operation discarded.
    @(posedge clk);
    #1;
    check("rst_discard", {14'd0, out_valid, Cout, S}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("no_pulse", {31'd0, out_valid}, 32'd0);
    add_check("post_rst", 16'h0F0F, 16'h00FF, 1'b0, 17'h0100E);

    // Random vectors against the 17-bit reference sum.
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      add_check("rand", ra, rb, rc, rexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
